cnt_share_sched: RTL and testbench
==================================

// Module: cnt_share_sched
// PURPOSE
//   Round-robin scheduler that shares one up/down counter between NUM_REQ requesters.
//   Each requester issues increment or decrement ops over a valid/ready handshake.
//   The block owns the counter register and applies at most one op per cycle.
//   A requester keeps ownership for a burst of up to BURST_LEN ops, then priority rotates.
// PARAMETERS
//   NUM_REQ    4  number of requesters (>=2)
//   CNT_W      4  counter width; value wraps modulo 2**CNT_W
//   BURST_LEN  2  max consecutive accepted ops per ownership (>=1)
// PORTS
//   clk        in   1                  clock, rising edge
//   reset      in   1                  synchronous, active-high
//   req_valid  in   NUM_REQ            requester i has an op pending
//   req_dir    in   NUM_REQ            op direction of requester i: 1=inc, 0=dec
//   req_ready  out  NUM_REQ            one-hot-or-zero grant; op i fires when valid&ready
//   grant_id   out  $clog2(NUM_REQ)    index of the granted requester (valid when op_fire=1)
//   op_fire    out  1                  an op is accepted this cycle
//   busy       out  1                  state==OWN (registered)
//   count      out  CNT_W              shared counter value (registered)
//   sat_hit    out  1                  op blocked by a limit (COUNT_SAT_EN only; else tied 0)
// BEHAVIOUR
//   - Reset: count=0, state=IDLE, owner=0, burst_cnt=0, last_grant=NUM_REQ-1, busy=0, sat_hit=0.
//     With reset asserted, req_ready=0 and op_fire=0 in that cycle.
//   - req_ready, grant_id and op_fire are combinational from state/regs and req_valid.
//     Ready may depend on valid. Requesters must not make valid depend on ready.
//   - Grant rule, evaluated each cycle:
//     OWN, req_valid[owner]=1 and burst_cnt<BURST_LEN -> grant owner.
//     Otherwise -> grant the first valid requester scanning from (last_grant+1) mod NUM_REQ.
//     In that scan the previous owner has lowest priority. No valid requester -> no grant.
//   - State transitions:
//     IDLE -> OWN on any grant: owner=grant_id, burst_cnt=1, last_grant=grant_id.
//     OWN, owner re-granted -> burst_cnt++.
//     OWN, another requester granted -> owner changes, burst_cnt=1.
//     OWN, no grant -> IDLE.
//   - Release costs no bubble. When the owner drops valid or exhausts its burst,
//     the next requester is granted in the same cycle.
//     A sole requester is re-granted back-to-back indefinitely.
//   - Count update: on op_fire, count <= count+1 (dir=1) or count-1 (dir=0) at the next edge.
//     Latency is 1 cycle. With no fire, count holds.
//   - Reset mid-burst aborts the ownership. An op presented in the reset cycle is not applied.
// CONFIGURATION
//   COUNT_SAT_EN defined:
//     - Inc at count=2**CNT_W-1 or dec at count=0 is still accepted (ready/op_fire=1).
//     - count holds in that case, and sat_hit is registered high for 1 cycle.
//   COUNT_SAT_EN undefined: count wraps in both directions; sat_hit is constant 0.
// STRUCTURE
//   Package cnt_share_pkg:
//     - state enum typedef {IDLE, OWN}
//     - constants DIR_INC=1'b1, DIR_DEC=1'b0
//   Sub-module cnt_share_rr_pick: combinational round-robin first-one finder.
//     - inputs: req vector, start index
//     - outputs: one-hot grant, index, found flag
//   Top level holds the FSM, burst counter, last_grant, count register and saturation logic.
// TESTING (NUM_REQ=4, CNT_W=4, BURST_LEN=2)
//   1. Reset 2 cycles, no valids -> count=0, req_ready=0, busy=0, op_fire=0.
//   2. req_valid=0001, dir=1 for 5 cycles -> ready[0]=1 every cycle, count 0->5, no bubbles.
//   3. req_valid=0101, all inc, held -> grant_id sequence 0,0,2,2,0,0; count +1 per cycle.
//   4. count=15 with inc -> wrap to 0 without macro; with COUNT_SAT_EN stays 15, sat_hit=1 one cycle.
//      count=0 with dec -> 15 without macro; with COUNT_SAT_EN stays 0, sat_hit=1.
//   5. req1 owns, burst_cnt=1, req3 valid; req1 drops valid -> req3 granted that same cycle.
//   6. Reset during req1 burst -> next cycle count=0, busy=0, and with 1111 valid, grant_id=0.

Source files
------------

// File: rtl/cnt_share_pkg.sv
// Shared types and constants for the round-robin shared-counter scheduler.
package cnt_share_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    // Next index after idx, wrapping at n.
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/cnt_share_rr_pick.sv
// Combinational round-robin first-one finder: first set bit of req at or after start.
module cnt_share_rr_pick
    import cnt_share_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] start,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] idx,
    output logic                 found
);

    localparam int unsigned IW = $clog2(N);

    always_comb begin
        int unsigned j;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 32'(start);
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && req[IW'(j)]) begin
                found          = 1'b1;
                idx            = IW'(j);
                grant[IW'(j)]  = 1'b1;
            end
            j = rr_next(j, N);
        end
    end

endmodule

// File: rtl/cnt_share_sched.sv
// Round-robin scheduler sharing one up/down counter among NUM_REQ requesters with bursts.
// Optional macro COUNT_SAT_EN: counter saturates instead of wrapping and flags sat_hit.
module cnt_share_sched
    import cnt_share_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned CNT_W     = 4,
    parameter int unsigned BURST_LEN = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ-1:0]         req_dir,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [$clog2(NUM_REQ)-1:0] grant_id,
    output logic                       op_fire,
    output logic                       busy,
    output logic [CNT_W-1:0]           count,
    output logic                       sat_hit
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned BW = $clog2(BURST_LEN + 1);

    state_t         state;
    logic [IW-1:0]  owner;
    logic [IW-1:0]  last_grant;
    logic [BW-1:0]  burst_cnt;

    logic               keep;
    logic [IW-1:0]      scan_start;
    logic [NUM_REQ-1:0] pick_grant;
    logic [IW-1:0]      pick_idx;
    logic               pick_found;
    logic [IW-1:0]      grant_idx;
    logic               grant_any;
    logic               sel_dir;

    // Owner keeps the counter while it is valid and its burst is not exhausted.
    assign keep       = (state == OWN) && req_valid[owner] && (burst_cnt < BW'(BURST_LEN));
    assign scan_start = IW'(rr_next(32'(last_grant), NUM_REQ));

    cnt_share_rr_pick #(
        .N (NUM_REQ)
    ) u_pick (
        .req   (req_valid),
        .start (scan_start),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign grant_idx = keep ? owner : pick_idx;
    assign grant_any = keep || pick_found;
    assign sel_dir   = req_dir[grant_idx];

    assign op_fire   = grant_any && !reset;
    assign grant_id  = grant_idx;
    assign req_ready = !op_fire ? '0 : (keep ? (NUM_REQ'(1) << owner) : pick_grant);

`ifdef COUNT_SAT_EN
    logic at_limit;
    assign at_limit = (sel_dir == DIR_INC) ? (count == '1) : (count == '0);
`else
    assign sat_hit = 1'b0;
`endif

    // Ownership FSM, burst tracking and counter update.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            burst_cnt  <= '0;
            busy       <= 1'b0;
            count      <= '0;
`ifdef COUNT_SAT_EN
            sat_hit    <= 1'b0;
`endif
        end else begin
`ifdef COUNT_SAT_EN
            sat_hit <= 1'b0;
`endif
            if (grant_any) begin
                state      <= OWN;
                busy       <= 1'b1;
                owner      <= grant_idx;
                last_grant <= grant_idx;
                // Re-grant to a burst-exhausted sole requester saturates rather than wraps.
                if (state == OWN && grant_idx == owner) begin
                    if (burst_cnt < BW'(BURST_LEN))
                        burst_cnt <= burst_cnt + BW'(1);
                end else begin
                    burst_cnt <= BW'(1);
                end
`ifdef COUNT_SAT_EN
                if (at_limit)
                    sat_hit <= 1'b1;
                else
                    count <= (sel_dir == DIR_INC) ? count + CNT_W'(1) : count - CNT_W'(1);
`else
                count <= (sel_dir == DIR_INC) ? count + CNT_W'(1) : count - CNT_W'(1);
`endif
            end else begin
                state     <= IDLE;
                busy      <= 1'b0;
                burst_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cnt_share_sched.sv
// Self-checking bench for cnt_share_sched: directed scenarios plus randomized model comparison.
module tb_cnt_share_sched;

    localparam int N  = 4;
    localparam int BL = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_valid;
    logic [3:0] req_dir;
    logic [3:0] req_ready;
    logic [1:0] grant_id;
    logic       op_fire;
    logic       busy;
    logic [3:0] count;
    logic       sat_hit;

    int tests = 0;
    int fails = 0;

    cnt_share_sched #(.NUM_REQ(4), .CNT_W(4), .BURST_LEN(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_dir   (req_dir),
        .req_ready (req_ready),
        .grant_id  (grant_id),
        .op_fire   (op_fire),
        .busy      (busy),
        .count     (count),
        .sat_hit   (sat_hit)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req_valid = '0; req_dir = '0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b1; req_valid = 4'b1111; req_dir = 4'b1111;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++;
            if (req_ready !== 4'b0000 || op_fire !== 1'b0) begin
                fails++;
                $display("FAIL reset_gate: ready=%b fire=%b, want 0000/0", req_ready, op_fire);
            end
            @(posedge clk); #1;
            tests++;
            if (count !== 4'd0 || busy !== 1'b0 || sat_hit !== 1'b0) begin
                fails++;
                $display("FAIL reset_state: count=%0d busy=%b sat=%b, want 0/0/0", count, busy, sat_hit);
            end
            @(negedge clk);
        end
        reset = 1'b0; req_valid = '0;
        #1;
        tests++;
        if (req_ready !== 4'b0000 || op_fire !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_after_reset: ready=%b fire=%b busy=%b", req_ready, op_fire, busy);
        end
    endtask

    task automatic test_sole();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 4'b0001; req_dir = 4'b0001;
            #1;
            tests++;
            if (req_ready !== 4'b0001 || op_fire !== 1'b1 || grant_id !== 2'd0) begin
                fails++;
                $display("FAIL sole_grant[%0d]: ready=%b fire=%b id=%0d, want 0001/1/0", i, req_ready, op_fire, grant_id);
            end
            @(posedge clk); #1;
            tests++;
            if (count !== 4'(i + 1) || busy !== 1'b1) begin
                fails++;
                $display("FAIL sole_count[%0d]: count=%0d busy=%b, want %0d/1", i, count, busy, i + 1);
            end
        end
        @(negedge clk); req_valid = '0;
    endtask

    task automatic test_alternate();
        int exp_id [6] = '{0, 0, 2, 2, 0, 0};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            req_valid = 4'b0101; req_dir = 4'b1111;
            #1;
            tests++;
            if (op_fire !== 1'b1 || grant_id !== 2'(exp_id[i]) || req_ready !== 4'(1 << exp_id[i])) begin
                fails++;
                $display("FAIL alt_grant[%0d]: id=%0d ready=%b fire=%b, want id %0d", i, grant_id, req_ready, op_fire, exp_id[i]);
            end
            @(posedge clk); #1;
            tests++;
            if (count !== 4'(i + 1)) begin
                fails++;
                $display("FAIL alt_count[%0d]: count=%0d, want %0d", i, count, i + 1);
            end
        end
        @(negedge clk); req_valid = '0;
    endtask

    task automatic test_wrap();
        logic [3:0] exp_c;
        logic       exp_s;
        // Decrement at zero.
        do_reset();
        @(negedge clk);
        req_valid = 4'b0100; req_dir = 4'b0000;
`ifdef COUNT_SAT_EN
        exp_c = 4'd0;  exp_s = 1'b1;
`else
        exp_c = 4'd15; exp_s = 1'b0;
`endif
        #1;
        tests++;
        if (op_fire !== 1'b1 || req_ready !== 4'b0100) begin
            fails++;
            $display("FAIL dec_low_accept: fire=%b ready=%b, want 1/0100", op_fire, req_ready);
        end
        @(posedge clk); #1;
        tests++;
        if (count !== exp_c || sat_hit !== exp_s) begin
            fails++;
            $display("FAIL dec_low: count=%0d sat=%b, want %0d/%b", count, sat_hit, exp_c, exp_s);
        end
        @(negedge clk); req_valid = '0;
        @(posedge clk); #1;
        tests++;
        if (sat_hit !== 1'b0 || count !== exp_c) begin
            fails++;
            $display("FAIL dec_low_hold: count=%0d sat=%b, want %0d/0", count, sat_hit, exp_c);
        end
        // Increment at all-ones.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            @(negedge clk); req_valid = 4'b0001; req_dir = 4'b0001;
        end
        @(negedge clk);
        tests++;
        if (count !== 4'd15) begin
            fails++;
            $display("FAIL inc_fill: count=%0d, want 15", count);
        end
`ifdef COUNT_SAT_EN
        exp_c = 4'd15; exp_s = 1'b1;
`else
        exp_c = 4'd0;  exp_s = 1'b0;
`endif
        @(posedge clk); #1;
        tests++;
        if (count !== exp_c || sat_hit !== exp_s) begin
            fails++;
            $display("FAIL inc_high: count=%0d sat=%b, want %0d/%b", count, sat_hit, exp_c, exp_s);
        end
        @(negedge clk); req_valid = '0;
        @(posedge clk); #1;
        tests++;
        if (sat_hit !== 1'b0) begin
            fails++;
            $display("FAIL inc_high_pulse: sat=%b, want 0", sat_hit);
        end
    endtask

    task automatic test_release();
        do_reset();
        @(negedge clk);
        req_valid = 4'b0010; req_dir = 4'b1111;
        @(negedge clk);
        req_valid = 4'b1000;
        #1;
        tests++;
        if (op_fire !== 1'b1 || grant_id !== 2'd3 || req_ready !== 4'b1000) begin
            fails++;
            $display("FAIL release_same_cycle: id=%0d ready=%b fire=%b, want 3/1000/1", grant_id, req_ready, op_fire);
        end
        @(posedge clk); #1;
        tests++;
        if (count !== 4'd2 || busy !== 1'b1) begin
            fails++;
            $display("FAIL release_count: count=%0d busy=%b, want 2/1", count, busy);
        end
        @(negedge clk); req_valid = '0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk);
        req_valid = 4'b0010; req_dir = 4'b1111;
        @(negedge clk);
        reset = 1'b1;
        #1;
        tests++;
        if (op_fire !== 1'b0 || req_ready !== 4'b0000) begin
            fails++;
            $display("FAIL reset_mid_gate: fire=%b ready=%b, want 0/0000", op_fire, req_ready);
        end
        @(posedge clk); #1;
        tests++;
        if (count !== 4'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_state: count=%0d busy=%b, want 0/0", count, busy);
        end
        @(negedge clk);
        reset = 1'b0; req_valid = 4'b1111;
        #1;
        tests++;
        if (op_fire !== 1'b1 || grant_id !== 2'd0) begin
            fails++;
            $display("FAIL reset_mid_regrant: id=%0d fire=%b, want 0/1", grant_id, op_fire);
        end
        @(negedge clk); req_valid = '0;
    endtask

    task automatic test_random();
        bit         m_own;
        int         m_owner, m_burst, m_last, m_count, g;
        bit         m_sat, inc, rst;
        logic [3:0] v, d, exp_ready;
        do_reset();
        m_own = 0; m_owner = 0; m_burst = 0; m_last = N - 1; m_count = 0; m_sat = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 39) == 0);
            v   = 4'($urandom) & 4'($urandom | $urandom);
            d   = 4'($urandom);
            reset = rst; req_valid = v; req_dir = d;
            g = -1;
            if (!rst) begin
                if (m_own && v[m_owner] && m_burst < BL) g = m_owner;
                else
                    for (int k = 1; k <= N; k++)
                        if (g < 0 && v[(m_last + k) % N]) g = (m_last + k) % N;
            end
            exp_ready = (g >= 0) ? 4'(1 << g) : 4'b0000;
            #1;
            tests++;
            if (req_ready !== exp_ready || op_fire !== (g >= 0) || (g >= 0 && grant_id !== 2'(g))) begin
                fails++;
                $display("FAIL rnd_grant[%0d]: ready=%b fire=%b id=%0d, want ready=%b", cyc, req_ready, op_fire, grant_id, exp_ready);
            end
            m_sat = 0;
            if (rst) begin
                m_own = 0; m_owner = 0; m_burst = 0; m_last = N - 1; m_count = 0;
            end else if (g >= 0) begin
                m_burst = (m_own && g == m_owner) ? m_burst + 1 : 1;
                m_own = 1; m_owner = g; m_last = g;
                inc = d[g];
`ifdef COUNT_SAT_EN
                if ((inc && m_count == 15) || (!inc && m_count == 0)) m_sat = 1;
                else m_count = inc ? m_count + 1 : m_count - 1;
`else
                m_count = (m_count + (inc ? 1 : 15)) % 16;
`endif
            end else begin
                m_own = 0; m_burst = 0;
            end
            @(posedge clk); #1;
            tests++;
            if (count !== 4'(m_count) || busy !== m_own || sat_hit !== m_sat) begin
                fails++;
                $display("FAIL rnd_state[%0d]: count=%0d busy=%b sat=%b, want %0d/%b/%b", cyc, count, busy, sat_hit, m_count, m_own, m_sat);
            end
        end
        @(negedge clk); reset = 1'b0; req_valid = '0;
    endtask

    initial begin
        reset = 1'b1; req_valid = '0; req_dir = '0;
        test_reset();
        test_sole();
        test_alternate();
        test_wrap();
        test_release();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
